// File: rtl/subtractor_scheduler.sv
// Round-robin scheduler sharing one registered subtractor between NCH channel
// pairs; per-channel results are captured by tag and exposed over the PS register bus.

module subtractor_scheduler_lane #(
  parameter int DW = 14
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cap,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] res,
  output logic          vld
);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      res <= '0;
      vld <= 1'b0;
    end else begin
      vld <= cap;
      if (cap) res <= din;
    end
  end
endmodule

module subtractor_scheduler #(
  parameter int NCH     = 4,
  parameter int DW      = 14,
  parameter int SUB_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NCH*DW-1:0] plus_i,
  input  logic [NCH*DW-1:0] minus_i,
  output logic [DW-1:0]     sub_plus_o,
  output logic [DW-1:0]     sub_minus_o,
  input  logic [DW-1:0]     sub_out_i,
  output logic [NCH*DW-1:0] res_o,
  output logic [NCH-1:0]    res_valid_o,
  input  logic [15:0]       addr,
  input  logic              wen,
  input  logic              ren,
  output logic              ack,
  output logic [31:0]       rdata,
  input  logic [31:0]       wdata
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                     state;
  logic                       run;
  logic [NCH-1:0]             mask;
  logic [CW-1:0]              last, sel_ch;
  logic [31:0]                rounds;
  logic [7:0]                 drain_cnt;
  logic [SUB_LAT:0]           vld_pipe;
  logic [SUB_LAT:0][CW-1:0]   ch_pipe;
  logic [NCH-1:0][DW-1:0]     plus_arr, minus_arr, res_arr;
  logic                       go, issue;
  logic [31:0]                rd_val;
  int                         idx;

  assign plus_arr  = plus_i;
  assign minus_arr = minus_i;
  assign res_o     = res_arr;
  assign go        = run && (mask != '0);
  assign issue     = (state == RUN) && go;

  // Scan farthest-first so the nearest enabled channel after last wins.
  always_comb begin
    sel_ch = last;
    idx    = 0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (int'(last) + i) % NCH;
      if (mask[idx]) sel_ch = CW'(idx);
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (addr[7:0])
      8'h00: rd_val = {31'b0, run};
      8'h04: rd_val[NCH-1:0] = mask;
      8'h08: rd_val = {25'b0, 3'(last), 2'b0, state};
      8'h0C: rd_val = rounds;
      default: begin
        for (int k = 0; k < NCH; k++)
          if (addr[7:0] == 8'(16 + 4*k))
            rd_val = {{(32-DW){res_arr[k][DW-1]}}, res_arr[k]};
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      run         <= 1'b0;
      mask        <= '0;
      last        <= CW'(NCH-1);
      rounds      <= '0;
      drain_cnt   <= '0;
      vld_pipe    <= '0;
      ch_pipe     <= '0;
      sub_plus_o  <= '0;
      sub_minus_o <= '0;
      ack         <= 1'b0;
      rdata       <= '0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_val : '0;
      if (wen) begin
        if (addr[7:0] == 8'h00) run  <= wdata[0];
        if (addr[7:0] == 8'h04) mask <= wdata[NCH-1:0];
      end

      // Tag travels alongside the operands so its tail lines up with sub_out_i.
      vld_pipe[0] <= issue;
      ch_pipe[0]  <= sel_ch;
      for (int i = 1; i <= SUB_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ch_pipe[i]  <= ch_pipe[i-1];
      end

      if (issue) begin
        sub_plus_o  <= plus_arr[sel_ch];
        sub_minus_o <= minus_arr[sel_ch];
        last        <= sel_ch;
        if (sel_ch <= last) rounds <= rounds + 32'd1;
      end

      unique case (state)
        IDLE:  if (go) state <= RUN;
        RUN:   if (!go) begin
                 state     <= DRAIN;
                 drain_cnt <= '0;
               end
        DRAIN: if (go) state <= RUN;
               else if (drain_cnt == 8'(SUB_LAT)) state <= IDLE;
               else drain_cnt <= drain_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    subtractor_scheduler_lane #(.DW(DW)) u_lane (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .cap    (vld_pipe[SUB_LAT] && (ch_pipe[SUB_LAT] == CW'(k))),
      .din    (sub_out_i),
      .res    (res_arr[k]),
      .vld    (res_valid_o[k])
    );
  end
endmodule

// File: tb/tb_subtractor_scheduler.sv
// Randomized bench for subtractor_scheduler against a queue-based reference model
// plus directed checks of ordering, rounds, negative saturation, drain and bus corners.

module tb_subtractor_scheduler;
  localparam int NCH = 4, DW = 14, SUB_LAT = 1;

  logic              clk_i = 1'b0, rstn_i = 1'b1;
  logic [NCH*DW-1:0] plus_i = '0, minus_i = '0, res_o;
  logic [DW-1:0]     sub_plus_o, sub_minus_o, sub_out_i = '0;
  logic [NCH-1:0]    res_valid_o;
  logic [15:0]       addr = '0;
  logic              wen = 1'b0, ren = 1'b0, ack;
  logic [31:0]       rdata, wdata = '0;

  always #5 clk_i = ~clk_i;

  subtractor_scheduler #(.NCH(NCH), .DW(DW), .SUB_LAT(SUB_LAT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .plus_i(plus_i), .minus_i(minus_i),
    .sub_plus_o(sub_plus_o), .sub_minus_o(sub_minus_o), .sub_out_i(sub_out_i),
    .res_o(res_o), .res_valid_o(res_valid_o), .addr(addr), .wen(wen), .ren(ren),
    .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  // Shared subtractor: one-cycle registered (plus - minus) >> 1 on a 15-bit difference.
  logic signed [DW:0] diff;
  assign diff = {sub_plus_o[DW-1], sub_plus_o} - {sub_minus_o[DW-1], sub_minus_o};
  always @(posedge clk_i) sub_out_i <= diff[DW:1];

  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int ch; logic [DW-1:0] val; } pend_t;
  pend_t              pq[$];
  int                 cyc, m_state, m_drain, m_last, sch, c;
  logic               m_run, m_ack;
  logic [NCH-1:0]     m_mask, m_pulse;
  logic [31:0]        m_rounds, m_rdata, rv;
  logic [DW-1:0]      m_res [NCH];
  logic [DW-1:0]      m_sp, m_sm;
  logic signed [DW-1:0] ps, ms;
  int                 dv;

  function automatic logic [31:0] mread(input logic [15:0] a);
    logic [31:0] r;
    r = '0;
    if (a[7:0] == 8'h00) r = {31'b0, m_run};
    else if (a[7:0] == 8'h04) r = 32'(m_mask);
    else if (a[7:0] == 8'h08) r = 32'((m_last << 4) | m_state);
    else if (a[7:0] == 8'h0C) r = m_rounds;
    else for (int k = 0; k < NCH; k++)
      if (int'(a[7:0]) == 16 + 4*k) r = 32'($signed(m_res[k]));
    return r;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cyc = 0; m_state = 0; m_drain = 0; m_last = NCH-1; m_run = 0; m_mask = '0;
      m_rounds = '0; m_ack = 0; m_rdata = '0; m_pulse = '0; m_sp = '0; m_sm = '0;
      for (int k = 0; k < NCH; k++) m_res[k] = '0;
      pq.delete();
    end else begin
      rv = mread(addr);
      m_ack = wen | ren;
      m_rdata = ren ? rv : '0;
      cyc++;
      m_pulse = '0;
      while (pq.size() > 0 && pq[0].due == cyc) begin
        m_res[pq[0].ch] = pq[0].val;
        m_pulse[pq[0].ch] = 1'b1;
        void'(pq.pop_front());
      end
      if (m_state == 0) begin
        if (m_run && m_mask != 0) m_state = 1;
      end else if (m_state == 1) begin
        if (m_run && m_mask != 0) begin
          sch = -1;
          for (int i = 1; i <= NCH; i++) begin
            c = (m_last + i) % NCH;
            if (m_mask[c] && sch < 0) sch = c;
          end
          if (sch <= m_last) m_rounds = m_rounds + 1;
          m_last = sch;
          ps = plus_i[sch*DW +: DW];
          ms = minus_i[sch*DW +: DW];
          m_sp = ps; m_sm = ms;
          dv = (int'(ps) - int'(ms)) >>> 1;
          pq.push_back('{cyc + SUB_LAT + 1, sch, dv[DW-1:0]});
        end else begin
          m_state = 2; m_drain = 0;
        end
      end else begin
        if (m_run && m_mask != 0) m_state = 1;
        else if (m_drain == SUB_LAT) m_state = 0;
        else m_drain++;
      end
      if (wen && addr[7:0] == 8'h00) m_run = wdata[0];
      if (wen && addr[7:0] == 8'h04) m_mask = wdata[NCH-1:0];
    end
  end

  always @(negedge clk_i) if (rstn_i) begin
    chk("ack", 64'(ack), 64'(m_ack));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("res_valid", 64'(res_valid_o), 64'(m_pulse));
    chk("sub_plus", 64'(sub_plus_o), 64'(m_sp));
    chk("sub_minus", 64'(sub_minus_o), 64'(m_sm));
    for (int k = 0; k < NCH; k++) chk("res", 64'(res_o[k*DW +: DW]), 64'(m_res[k]));
  end

  // ---------------- stimulus ----------------
  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk_i);
    wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic set_ops(input int p0, input int mi);
    for (int k = 0; k < NCH; k++) begin
      plus_i[k*DW +: DW]  = DW'(p0 + k);
      minus_i[k*DW +: DW] = DW'(mi);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0004;
      2: return 16'h0008;
      3: return 16'h000C;
      4: return 16'(16 + 4*$urandom_range(0, NCH-1));
      5: return 16'h0040;
      6: return 16'($urandom());
      default: return 16'(16 + 4*NCH);
    endcase
  endfunction

  logic [31:0] d, r1, r2;
  logic [NCH-1:0] acc;
  int prev;

  initial begin
    #1 rstn_i = 1'b0;
    #1;
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_sub", 64'({sub_plus_o, sub_minus_o}), 64'd0);
    chk("rst_bus", 64'({ack, rdata, res_valid_o}), 64'd0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // All four channels: order 0,1,2,3 and results 400,400,401,401.
    set_ops(1000, 200);
    bus_wr(16'h04, 32'hF);
    bus_wr(16'h00, 32'h1);
    repeat (10) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      prev = int'(sub_plus_o);
      @(negedge clk_i);
      chk("order", 64'(sub_plus_o), 64'(1000 + ((prev - 1000 + 1) % 4)));
    end
    for (int k = 0; k < NCH; k++) begin
      bus_rd(16'(16 + 4*k), d);
      chk("res_bus", 64'(d), 64'(400 + k/2));
    end
    bus_rd(16'h0C, r1);
    repeat (7) @(negedge clk_i);
    bus_rd(16'h0C, r2);
    chk("rounds_f", 64'(r2 - r1), 64'd2);

    // Channels 0 and 2 only; 1 and 3 must stay quiet.
    set_ops(2000, 100);
    bus_wr(16'h04, 32'h5);
    repeat (3) @(negedge clk_i);
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      acc |= res_valid_o;
    end
    chk("mask5_vld", 64'(acc), 64'h5);

    // Single channel 1 mid-stream: one round per issue.
    bus_wr(16'h04, 32'h2);
    repeat (3) @(negedge clk_i);
    bus_rd(16'h0C, r1);
    repeat (3) @(negedge clk_i);
    bus_rd(16'h0C, r2);
    chk("rounds_1", 64'(r2 - r1), 64'd4);

    // Most negative difference.
    for (int k = 0; k < NCH; k++) begin
      plus_i[k*DW +: DW]  = 14'h2000;
      minus_i[k*DW +: DW] = 14'h1FFF;
    end
    bus_wr(16'h04, 32'h4);
    repeat (5) @(negedge clk_i);
    chk("neg_res", 64'(res_o[2*DW +: DW]), 64'h2000);
    bus_rd(16'h18, d);
    chk("neg_bus", 64'(d), 64'hFFFF_E000);

    // Stop after an issue to channel 2: drain two cycles then idle.
    bus_wr(16'h00, 32'h0);
    @(negedge clk_i);
    bus_rd(16'h08, d);
    chk("drain_st", 64'(d[6:0]), 64'h22);
    bus_rd(16'h08, d);
    chk("drain_st2", 64'(d[1:0]), 64'd2);
    bus_rd(16'h08, d);
    chk("idle_st", 64'(d[1:0]), 64'd0);

    // Bus corners.
    bus_rd(16'h0C, r1);
    bus_wr(16'h0C, 32'hDEAD);
    chk("wr_ro_ack", 64'(ack), 64'd1);
    bus_wr(16'h40, 32'hFFFF);
    chk("wr_unm_ack", 64'(ack), 64'd1);
    bus_rd(16'h0C, r2);
    chk("ro_keep", 64'(r2), 64'(r1));
    bus_rd(16'h40, d);
    chk("unm_rd", 64'(d), 64'd0);
    addr = 16'h04; ren = 1'b1;
    @(negedge clk_i);
    chk("b2b_ack1", 64'(ack), 64'd1);
    addr = 16'h08;
    @(negedge clk_i);
    ren = 1'b0;
    chk("b2b_ack2", 64'(ack), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      plus_i  = (NCH*DW)'({$urandom(), $urandom()});
      minus_i = (NCH*DW)'({$urandom(), $urandom()});
      wen = 1'b0; ren = 1'b0;
      case ($urandom_range(0, 9))
        0: begin addr = 16'h00; wdata = 32'($urandom_range(0, 3) != 0); wen = 1'b1; end
        1: begin addr = 16'h04; wdata = $urandom(); wen = 1'b1; end
        2: begin addr = pick_addr(); wdata = $urandom(); wen = 1'b1; end
        3, 4, 5: begin addr = pick_addr(); ren = 1'b1; end
        default: ;
      endcase
      @(negedge clk_i);
    end
    wen = 1'b0; ren = 1'b0;

    // Reset mid-run with results pending.
    set_ops(500, 7);
    bus_wr(16'h04, 32'hF);
    bus_wr(16'h00, 32'h1);
    repeat (4) @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_res", 64'(res_o), 64'd0);
    chk("arst_sub", 64'({sub_plus_o, sub_minus_o}), 64'd0);
    chk("arst_bus", 64'({ack, rdata, res_valid_o}), 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      acc |= res_valid_o;
    end
    chk("arst_nopulse", 64'(acc), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
